// File: rtl/vec_op_sequencer_pkg.sv
// Shared types and constants for the vector-op issue sequencer.
package vec_seq_pkg;

  localparam int INSTR_W = 30;
  localparam int OPC_MSB = 29;
  localparam int OPC_LSB = 26;
  localparam int IMM_W   = 16;

  typedef enum logic [3:0] {
    OP_INCRI = 4'd0,
    OP_INCRJ = 4'd1,
    OP_SETN  = 4'd2,
    OP_SUMFV = 4'd3,
    OP_MULFV = 4'd4,
    OP_NOP   = 4'd5
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_EXEC,
    S_WB
  } seq_state_t;

  // Opcodes above NOP are undefined.
  function automatic logic opc_is_legal(input logic [3:0] opc);
    return (opc <= 4'd5);
  endfunction

endpackage

// File: rtl/vec_op_sequencer_if.sv
// Decode / vector-ALU / data-memory signals seen by the sequencer.
// slave is the sequencer side, master is the surrounding decode/ALU/memory side.
interface vec_op_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic                              instr_valid;
  logic [vec_seq_pkg::INSTR_W-1:0]   instr;
  logic                              instr_ready;
  logic                              valu_start;
  logic                              valu_op;
  logic                              valu_done;
  logic                              rd_en;
  logic [ADDR_W-1:0]                 rd_addr;
  logic                              wr_en;
  logic [ADDR_W-1:0]                 wr_addr;

  modport master (
    output instr_valid, instr, valu_done,
    input  instr_ready, valu_start, valu_op, rd_en, rd_addr, wr_en, wr_addr
  );

  modport slave (
    input  instr_valid, instr, valu_done,
    output instr_ready, valu_start, valu_op, rd_en, rd_addr, wr_en, wr_addr
  );
endinterface

// File: rtl/vec_op_sequencer_idx_regs.sv
// Loop registers n, i, j with SETN load and wrap-at-n increments.
module vec_idx_regs #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_setn,
  input  logic             i_incri,
  input  logic             i_incrj,
  input  logic [IDX_W-1:0] i_imm,
  output logic [IDX_W-1:0] o_n,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j
);

  logic [IDX_W-1:0] r_n;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;

  // Increment with wrap to 0 once v+1 reaches the limit; one extra bit keeps
  // v+1 from overflowing, and a limit of 0 pins the result at 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v,
                                                input logic [IDX_W-1:0] lim);
    logic [IDX_W:0] s;
    s = {1'b0, v} + {{IDX_W{1'b0}}, 1'b1};
    return (s >= {1'b0, lim}) ? '0 : s[IDX_W-1:0];
  endfunction

  // Load or step the loop registers on accepted index instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n <= '0;
      r_i <= '0;
      r_j <= '0;
    end else if (i_setn) begin
      r_n <= i_imm;
      r_i <= '0;
      r_j <= '0;
    end else begin
      if (i_incri) r_i <= wrap_inc(r_i, r_n);
      if (i_incrj) r_j <= wrap_inc(r_j, r_n);
    end
  end

  assign o_n = r_n;
  assign o_i = r_i;
  assign o_j = r_j;

endmodule

// File: rtl/vec_op_sequencer.sv
// Issue controller: single-cycle index ops, and a read -> execute -> write-back
// sequence on the vector ALU for MULFV/SUMFV with decode stalled meanwhile.
module vec_op_sequencer
  import vec_seq_pkg::*;
#(
  parameter int                IDX_W        = 8,
  parameter int                ADDR_W       = 16,
  parameter int                MEM_RD_LAT   = 2,
  parameter int                EXEC_TIMEOUT = 64,
  parameter logic [ADDR_W-1:0] RES_BASE     = 16'h0100
) (
  input  logic                clk,
  input  logic                rst,
  vec_op_sequencer_if.slave   bus,
  output logic [IDX_W-1:0]    n_out,
  output logic [IDX_W-1:0]    i_out,
  output logic [IDX_W-1:0]    j_out,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_illegal
);

  localparam int CNT_MAX = (MEM_RD_LAT > EXEC_TIMEOUT) ? MEM_RD_LAT : EXEC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PROD_W  = 2 * IDX_W;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MEM_RD_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(EXEC_TIMEOUT - 1);

  seq_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rd_en, r_start, r_wr_en, r_valu_op;
  logic              r_err_to, r_err_ill;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;

  logic              w_rd_en_nxt, w_start_nxt, w_wr_en_nxt, w_timeout_hit;
  logic [3:0]        w_opc;
  logic              w_accept, w_is_vec, w_is_sum, w_unused;
  logic [IDX_W-1:0]  w_n, w_i, w_j;
  logic [PROD_W-1:0] w_prod;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_opc    = bus.instr[OPC_MSB:OPC_LSB];
  assign w_unused = ^bus.instr[OPC_LSB-1:0];
  assign bus.instr_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = bus.instr_valid && bus.instr_ready;
  assign w_is_sum = (w_opc == OP_SUMFV);
  assign w_is_vec = (w_opc == OP_MULFV) || w_is_sum;

  vec_idx_regs #(.IDX_W(IDX_W)) u_idx (
    .clk     (clk),
    .rst     (rst),
    .i_setn  (w_accept && (w_opc == OP_SETN)),
    .i_incri (w_accept && (w_opc == OP_INCRI)),
    .i_incrj (w_accept && (w_opc == OP_INCRJ)),
    .i_imm   (bus.instr[IDX_W-1:0]),
    .o_n     (w_n),
    .o_i     (w_i),
    .o_j     (w_j)
  );

  // Operand address i*n+j at double index width, result slot per op type.
  assign w_prod    = PROD_W'(w_i) * PROD_W'(w_n) + PROD_W'(w_j);
  assign w_wr_addr = w_is_sum ? (RES_BASE + ADDR_W'(w_n) + ADDR_W'(w_i))
                              : (RES_BASE + ADDR_W'(w_i));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next-cycle strobes; valu_done only counts after the start cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_en_nxt   = 1'b0;
    w_start_nxt   = 1'b0;
    w_wr_en_nxt   = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_vec) begin
          w_state_nxt = S_RD;
          w_rd_en_nxt = 1'b1;
        end
      end
      S_RD: begin
        if (r_cnt == RD_LAST) begin
          w_state_nxt = S_EXEC;
          w_start_nxt = 1'b1;
        end
      end
      S_EXEC: begin
        if (!r_start) begin
          if (bus.valu_done) begin
            w_state_nxt = S_WB;
            w_wr_en_nxt = 1'b1;
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt   = S_IDLE;
            w_timeout_hit = 1'b1;
          end
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cycle counter: read latency in RD, ALU wait in EXEC; cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_RD || (r_state == S_EXEC && !r_start)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered strobes, latched addresses/op and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en   <= 1'b0;
      r_start   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_valu_op <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_err_to  <= 1'b0;
      r_err_ill <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en_nxt;
      r_start   <= w_start_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_err_ill <= w_accept && !opc_is_legal(w_opc);
      if (w_timeout_hit) r_err_to <= 1'b1;
      if (w_accept && w_is_vec) begin
        r_valu_op <= w_is_sum;
        r_rd_addr <= ADDR_W'(w_prod);
        r_wr_addr <= w_wr_addr;
      end
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.valu_start = r_start;
  assign bus.valu_op    = r_valu_op;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign n_out          = w_n;
  assign i_out          = w_i;
  assign j_out          = w_j;
  assign busy           = (r_state != S_IDLE);
  assign err_timeout    = r_err_to;
  assign err_illegal    = r_err_ill;

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Directed bench for vec_op_sequencer: index ops, MULFV/SUMFV sequences,
// ALU timeout, illegal opcode and asynchronous reset mid-sequence.
module tb_vec_op_sequencer;
  import vec_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] n_out, i_out, j_out;
  logic       busy, err_timeout, err_illegal;

  vec_op_sequencer_if #(.ADDR_W(16)) bus ();

  vec_op_sequencer #(
    .IDX_W(8), .ADDR_W(16), .MEM_RD_LAT(2), .EXEC_TIMEOUT(64), .RES_BASE(16'h0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .n_out       (n_out),
    .i_out       (i_out),
    .j_out       (j_out),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one cycle; returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] opc, input logic [15:0] imm);
    @(negedge clk);
    check("ready_at_issue", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = {opc, 10'd0, imm};
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
  endtask

  // Full MULFV/SUMFV sequence with valu_done dly cycles after valu_start.
  task automatic run_vec(input logic [3:0] opc, input logic [15:0] exp_rd,
                         input logic [15:0] exp_wr, input logic exp_op,
                         input int dly, input bit done_at_start);
    issue(opc, 16'h0);
    check("rd_en_first", bus.rd_en, 1);
    check("rd_addr", bus.rd_addr, exp_rd);
    check("busy_rd", busy, 1);
    check("ready_rd", bus.instr_ready, 0);
    check("start_early", bus.valu_start, 0);
    @(negedge clk);
    check("rd_en_single", bus.rd_en, 0);
    check("start_not_yet", bus.valu_start, 0);
    @(negedge clk);
    check("valu_start", bus.valu_start, 1);
    check("valu_op", bus.valu_op, exp_op);
    check("ready_exec", bus.instr_ready, 0);
    if (done_at_start) bus.valu_done = 1'b1;
    @(negedge clk);
    bus.valu_done = 1'b0;
    check("start_single", bus.valu_start, 0);
    check("wr_en_early", bus.wr_en, 0);
    repeat (dly - 1) @(negedge clk);
    bus.valu_done = 1'b1;
    check("wr_en_wait", bus.wr_en, 0);
    check("ready_wait", bus.instr_ready, 0);
    @(negedge clk);
    bus.valu_done = 1'b0;
    check("wr_en", bus.wr_en, 1);
    check("wr_addr", bus.wr_addr, exp_wr);
    check("ready_wb", bus.instr_ready, 0);
    @(negedge clk);
    check("wr_en_single", bus.wr_en, 0);
    check("ready_back", bus.instr_ready, 1);
    check("busy_back", busy, 0);
  endtask

  initial begin
    int  cyc;
    bit  saw_wr;
    bit  saw_start;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.valu_done   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_nij", {n_out, i_out, j_out}, 0);
    check("rst_strobes", {bus.rd_en, bus.valu_start, bus.wr_en, bus.valu_op}, 0);
    check("rst_addrs", {bus.rd_addr, bus.wr_addr}, 0);
    check("rst_errs", {err_timeout, err_illegal}, 0);

    // SETN 8, INCRI x9: i wraps 7 -> 0
    issue(OP_SETN, 16'd8);
    check("setn8_n", n_out, 8);
    check("setn8_ij", {i_out, j_out}, 0);
    for (int k = 1; k <= 9; k++) begin
      issue(OP_INCRI, 16'd0);
      check("incri_i", i_out, k % 8);
      check("incri_j", j_out, 0);
    end

    // SETN 4, i=1, j=2, MULFV: rd 1*4+2=6, wr 0x100+1
    issue(OP_SETN, 16'd4);
    issue(OP_INCRI, 16'd0);
    issue(OP_INCRJ, 16'd0);
    issue(OP_INCRJ, 16'd0);
    check("pre_mul_ij", {i_out, j_out}, {8'd1, 8'd2});
    run_vec(OP_MULFV, 16'd6, 16'h0101, 1'b0, 5, 1'b0);
    check("mul_frozen", {n_out, i_out, j_out}, {8'd4, 8'd1, 8'd2});

    // SETN 4, i=2, SUMFV: rd 2*4+0=8, wr 0x100+4+2; done in start cycle ignored
    issue(OP_SETN, 16'd4);
    issue(OP_INCRI, 16'd0);
    issue(OP_INCRI, 16'd0);
    run_vec(OP_SUMFV, 16'd8, 16'h0106, 1'b1, 3, 1'b1);

    // MULFV with no valu_done: start at t+3, 64 counted cycles, flag seen at t+68
    issue(OP_MULFV, 16'd0);
    cyc    = 0;
    saw_wr = 1'b0;
    while (!err_timeout && cyc < 200) begin
      if (bus.wr_en) saw_wr = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("timeout_latency", cyc, 67);
    check("timeout_flag", err_timeout, 1);
    check("timeout_no_wr", saw_wr, 0);
    check("timeout_idle", {busy, bus.instr_ready}, 2'b01);
    issue(OP_NOP, 16'd0);
    check("nop_busy", busy, 0);
    check("nop_regs", {n_out, i_out, j_out}, {8'd4, 8'd2, 8'd0});
    check("timeout_sticky", err_timeout, 1);

    // Illegal opcode: single pulse, no state change
    issue(4'hF, 16'h0033);
    check("illegal_pulse", err_illegal, 1);
    check("illegal_regs", {n_out, i_out, j_out}, {8'd4, 8'd2, 8'd0});
    check("illegal_busy", busy, 0);
    @(negedge clk);
    check("illegal_clear", err_illegal, 0);

    // n == 0 holds i and j at 0
    issue(OP_SETN, 16'd0);
    check("setn0_n", n_out, 0);
    issue(OP_INCRI, 16'd0);
    check("n0_incri", i_out, 0);
    issue(OP_INCRJ, 16'd0);
    check("n0_incrj", j_out, 0);

    // Asynchronous reset during the valu_start cycle of a MULFV
    issue(OP_SETN, 16'd4);
    issue(OP_INCRI, 16'd0);
    issue(OP_MULFV, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_start", bus.valu_start, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_start", bus.valu_start, 0);
    check("arst_busy", busy, 0);
    check("arst_strobes", {bus.rd_en, bus.wr_en, bus.valu_op, bus.instr_ready}, 0);
    check("arst_addrs", {bus.rd_addr, bus.wr_addr}, 0);
    check("arst_regs", {n_out, i_out, j_out}, 0);
    check("arst_errs", {err_timeout, err_illegal}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.valu_done = 1'b1;
    saw_wr    = 1'b0;
    saw_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.wr_en) saw_wr = 1'b1;
      if (bus.valu_start) saw_start = 1'b1;
    end
    bus.valu_done = 1'b0;
    check("post_rst_no_wr", saw_wr, 0);
    check("post_rst_no_start", saw_start, 0);
    check("post_rst_idle", {busy, bus.instr_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_op_sequencer.md
Name: vec_op_sequencer

Overview:
Issue controller between the decode stage and the vector ALU / data memory of the vector CPU. Accepts one 30-bit instruction at a time and maintains the loop registers n, i and j. It executes SETN, INCRI, INCRJ and NOP in one cycle. For MULFV and SUMFV it runs a read → execute → write-back sequence on the vector ALU and stalls decode until that sequence completes.

Parameters:
IDX_W, 8, width of n, i, j
ADDR_W, 16, memory address width
MEM_RD_LAT, 2, cycles from rd_en to valid operand data (≥1)
EXEC_TIMEOUT, 64, max cycles waiting for valu_done
RES_BASE, 16'h0100, base address of result area

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  instr holds a valid instruction
instr  in  30  opcode [29:26], immediate [15:0]
instr_ready  out  1  sequencer can accept an instruction this cycle
valu_start  out  1  one-cycle start pulse to the vector ALU
valu_op  out  1  0 = MULFV (8 multiplier lanes), 1 = SUMFV (4 adder lanes)
valu_done  in  1  ALU result valid
rd_en  out  1  memory operand read strobe
rd_addr  out  ADDR_W  operand address
wr_en  out  1  result write strobe
wr_addr  out  ADDR_W  result address
n_out, i_out, j_out  out  IDX_W each  current loop registers
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky flag; set by an ALU timeout
err_illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - n, i, j, all strobes, addresses and error flags are 0.
  - instr_ready is 1 once rst deasserts.
- Accept: an instruction is accepted when instr_valid && instr_ready. instr_ready = (state==IDLE).
- Opcodes:
  - 0000 INCRI, 0001 INCRJ, 0010 SETN, 0011 SUMFV, 0100 MULFV, 0101 NOP.
  - 0110–1111 are illegal: accepted, err_illegal pulses the next cycle, no other effect.
- SETN: n <= imm[IDX_W-1:0], and i, j <= 0. Takes effect the cycle after acceptance.
- INCRI: i <= (i+1 >= n) ? 0 : i+1. INCRJ uses the same rule on j.
  - If n==0, i and j hold at 0.
  - Width is IDX_W, so there is no overflow past n.
- NOP: no state change. FSM stays in IDLE.
- MULFV / SUMFV FSM, IDLE → RD → EXEC → WB → IDLE:
  - RD:
    - First cycle: rd_en=1 for exactly one cycle.
    - rd_addr = i*n + j, computed at IDX_W*2 bits then zero-extended or truncated to ADDR_W.
    - Wait MEM_RD_LAT cycles counted from rd_en, then go to EXEC.
  - EXEC:
    - First cycle: valu_start=1 for exactly one cycle, valu_op latched from the opcode.
    - Wait for valu_done, counting cycles. On valu_done go to WB.
    - If the count reaches EXEC_TIMEOUT without valu_done: set err_timeout, go to IDLE, no write.
    - valu_done in the same cycle as valu_start is ignored; counting starts the next cycle.
  - WB:
    - wr_en=1 for one cycle.
    - wr_addr = RES_BASE + i for MULFV, RES_BASE + n + i for SUMFV.
    - Then IDLE.
- Latency: a MULFV accepted at cycle t gives rd_en at t+1 and valu_start at t+1+MEM_RD_LAT. With the done response at cycle d, wr_en is at d+1 and instr_ready returns at d+2.
- Loop registers are frozen while busy. Addresses use the values latched at acceptance.
- valu_done while in IDLE, RD or WB is ignored.
- rst mid-sequence aborts immediately: no wr_en and no valu_start is issued afterward.
- err_timeout clears only on rst.

Decomposition:
- Package vec_seq_pkg:
  - opcode enum op_t (INCRI, INCRJ, SETN, SUMFV, MULFV, NOP).
  - FSM state enum seq_state_t.
  - OPC_MSB/OPC_LSB and IMM_W constants.
- One sub-module, vec_idx_regs: holds n/i/j with the SETN/INCRI/INCRJ wrap logic. The FSM, address generation and timeout counter stay in the top level.

Test Plan:
- SETN imm=8, then INCRI ×9 → i_out steps 1..7, 0, 1. j_out stays 0. instr_ready is 1 throughout.
- SETN 4, INCRI, INCRJ ×2, MULFV; ALU model asserts valu_done 5 cycles after start → rd_addr=6 with rd_en one cycle, valu_start at accept+3 (MEM_RD_LAT=2), wr_addr=16'h0101, instr_ready is 0 for the whole sequence.
- SETN 4, INCRI ×2, SUMFV → valu_op=1, wr_addr=16'h0106.
- MULFV with valu_done never asserted → err_timeout=1 after 64 EXEC cycles, no wr_en, FSM back to IDLE. A following NOP is accepted.
- Opcode 1111 → err_illegal single pulse, n/i/j unchanged. SETN 0 then INCRI → i stays 0.
- Assert rst during EXEC of MULFV → all outputs 0 asynchronously, no wr_en afterward, busy=0.
